// File: rtl/mcu51_timer0.sv
// mcu51_timer0 - 8051-style Timer/Counter 0 peripheral.
//
// Holds TMOD, TCON, TL0 and TH0 on the core's SFR bus and counts either
// machine cycles (timer mode) or falling edges on t0_pin (counter mode).
// An overflow sets TF0, which is exported as the interrupt request tf0.
//
// Ports:
//   CLK        system clock
//   reset      asynchronous active-high reset
//   mc_tick    one-CLK pulse per machine cycle
//   sfr_addr   SFR address from the core
//   sfr_wdata  SFR write data
//   sfr_we     SFR write strobe (one CLK)
//   sfr_rdata  combinational read data, 8'h00 when the address misses
//   sfr_hit    address matches one of the four timer SFRs
//   t0_pin     external count input (asynchronous)
//   int0_n     external INT0 pin (asynchronous), used only for gating
//   int_ack    one-CLK acknowledge when the Timer 0 vector is taken
//   tf0        overflow flag / interrupt request (TCON bit 5)

module mcu51_timer0 #(
    parameter logic [7:0] TMOD_ADDR = 8'h89,
    parameter logic [7:0] TCON_ADDR = 8'h88,
    parameter logic [7:0] TL0_ADDR  = 8'h8A,
    parameter logic [7:0] TH0_ADDR  = 8'h8C
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       mc_tick,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    input  logic       sfr_we,
    output logic [7:0] sfr_rdata,
    output logic       sfr_hit,
    input  logic       t0_pin,
    input  logic       int0_n,
    input  logic       int_ack,
    output logic       tf0
);

    logic [7:0] tmod, tcon, tl0, th0;
    logic [7:0] next_tl0, next_th0, tcon_d;
    logic       t0_meta, t0_sync, t0_prev;
    logic       int0_meta, int0_sync;
    logic       wr_tmod, wr_tcon, wr_tl0, wr_th0;
    logic       run, inc, cnt_en, ovf, ovf_evt;

    assign wr_tmod = sfr_we && (sfr_addr == TMOD_ADDR);
    assign wr_tcon = sfr_we && (sfr_addr == TCON_ADDR);
    assign wr_tl0  = sfr_we && (sfr_addr == TL0_ADDR);
    assign wr_th0  = sfr_we && (sfr_addr == TH0_ADDR);

    // Two-flop synchronizers for the asynchronous pins; they idle high.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            t0_meta   <= 1'b1;
            t0_sync   <= 1'b1;
            int0_meta <= 1'b1;
            int0_sync <= 1'b1;
        end else begin
            t0_meta   <= t0_pin;
            t0_sync   <= t0_meta;
            int0_meta <= int0_n;
            int0_sync <= int0_meta;
        end
    end

    // Pin sample taken once per machine cycle, so a counter-mode edge is
    // recognised as "high last machine cycle, low this one".
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            t0_prev <= 1'b1;
        end else if (mc_tick) begin
            t0_prev <= t0_sync;
        end
    end

    assign run = tcon[4] && (!tmod[3] || int0_sync);
    assign inc = mc_tick && run && (tmod[2] ? (t0_prev && !t0_sync) : 1'b1);

    // A software write to either count byte swallows this cycle's increment
    // entirely, including any overflow it would have produced.
    assign cnt_en  = inc && !wr_tl0 && !wr_th0;
    assign ovf_evt = cnt_en && ovf;

    // Incremented count value and overflow condition for the current mode.
    always_comb begin
        next_tl0 = tl0;
        next_th0 = th0;
        ovf      = 1'b0;
        case (tmod[1:0])
            2'd0: begin
                // TL0[7:5] are held; TL0[4:0] acts as a prescaler below TH0.
                {next_th0, next_tl0[4:0]} = {th0, tl0[4:0]} + 13'd1;
                ovf = (th0 == 8'hFF) && (tl0[4:0] == 5'h1F);
            end
            2'd1: begin
                {next_th0, next_tl0} = {th0, tl0} + 16'd1;
                ovf = ({th0, tl0} == 16'hFFFF);
            end
            2'd2: begin
                if (tl0 == 8'hFF) begin
                    next_tl0 = th0;
                    ovf      = 1'b1;
                end else begin
                    next_tl0 = tl0 + 8'd1;
                end
            end
            default: begin
                next_tl0 = tl0 + 8'd1;
                ovf      = (tl0 == 8'hFF);
            end
        endcase
    end

    // TCON update: a write replaces the byte, int_ack clears TF0 when no
    // write is present, and a hardware overflow always sets TF0 last.
    always_comb begin
        tcon_d = tcon;
        if (wr_tcon) begin
            tcon_d = sfr_wdata;
        end else if (int_ack) begin
            tcon_d[5] = 1'b0;
        end
        if (ovf_evt) begin
            tcon_d[5] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tmod <= 8'h00;
            tcon <= 8'h00;
            tl0  <= 8'h00;
            th0  <= 8'h00;
        end else begin
            tcon <= tcon_d;
            if (wr_tmod) begin
                tmod <= sfr_wdata;
            end
            if (wr_tl0) begin
                tl0 <= sfr_wdata;
            end else if (cnt_en) begin
                tl0 <= next_tl0;
            end
            if (wr_th0) begin
                th0 <= sfr_wdata;
            end else if (cnt_en) begin
                th0 <= next_th0;
            end
        end
    end

    assign tf0 = tcon[5];

    always_comb begin
        sfr_rdata = 8'h00;
        sfr_hit   = 1'b1;
        if (sfr_addr == TMOD_ADDR) begin
            sfr_rdata = tmod;
        end else if (sfr_addr == TCON_ADDR) begin
            sfr_rdata = tcon;
        end else if (sfr_addr == TL0_ADDR) begin
            sfr_rdata = tl0;
        end else if (sfr_addr == TH0_ADDR) begin
            sfr_rdata = th0;
        end else begin
            sfr_hit = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcu51_timer0.sv
// tb_mcu51_timer0 - self-checking bench for mcu51_timer0.
//
// Directed mode vectors from a table, hand-written corner sequences
// (int_ack, gating, collisions, reset mid-count) and a randomized run
// compared against an arithmetic model of the timer.

module tb_mcu51_timer0;

    localparam logic [7:0] A_TCON = 8'h88;
    localparam logic [7:0] A_TMOD = 8'h89;
    localparam logic [7:0] A_TL0  = 8'h8A;
    localparam logic [7:0] A_TH0  = 8'h8C;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       mc_tick = 1'b0;
    logic [7:0] sfr_addr = 8'h00;
    logic [7:0] sfr_wdata = 8'h00;
    logic       sfr_we = 1'b0;
    logic [7:0] sfr_rdata;
    logic       sfr_hit;
    logic       t0_pin = 1'b1;
    logic       int0_n = 1'b1;
    logic       int_ack = 1'b0;
    logic       tf0;

    int tests = 0;
    int fails = 0;

    // Reference model state for the randomized run
    logic [7:0] m_tmod, m_tcon, m_tl, m_th;
    logic       m_int0;

    typedef struct {
        logic [7:0] tmod;
        logic [7:0] tcon;
        logic [7:0] th;
        logic [7:0] tl;
        int         ticks;
        logic [7:0] exp_th;
        logic [7:0] exp_tl;
        logic       exp_tf;
    } vec_t;

    vec_t vecs[10];

    mcu51_timer0 dut (
        .CLK      (CLK),
        .reset    (reset),
        .mc_tick  (mc_tick),
        .sfr_addr (sfr_addr),
        .sfr_wdata(sfr_wdata),
        .sfr_we   (sfr_we),
        .sfr_rdata(sfr_rdata),
        .sfr_hit  (sfr_hit),
        .t0_pin   (t0_pin),
        .int0_n   (int0_n),
        .int_ack  (int_ack),
        .tf0      (tf0)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        sfr_addr  = a;
        sfr_wdata = d;
        sfr_we    = 1'b1;
        cycle();
        sfr_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        sfr_addr = a;
        #1;
        d = sfr_rdata;
    endtask

    task automatic tick();
        mc_tick = 1'b1;
        cycle();
        mc_tick = 1'b0;
        repeat (11) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e_tmod, input logic [7:0] e_tcon,
                              input logic [7:0] e_tl, input logic [7:0] e_th);
        logic [7:0] d;
        rd(A_TMOD, d); checkOutput({tag, " tmod"}, d, e_tmod);
        rd(A_TCON, d); checkOutput({tag, " tcon"}, d, e_tcon);
        rd(A_TL0,  d); checkOutput({tag, " tl0"},  d, e_tl);
        rd(A_TH0,  d); checkOutput({tag, " th0"},  d, e_th);
        checkOutput({tag, " tf0"}, {7'd0, tf0}, {7'd0, e_tcon[5]});
    endtask

    task automatic t0_pulse();
        t0_pin = 1'b0;
        tick();
        tick();
        t0_pin = 1'b1;
        tick();
        tick();
    endtask

    // One model cycle: arithmetic view of the count register per mode.
    task automatic model_step(input bit tk, input bit we, input logic [7:0] a,
                              input logic [7:0] d, input bit ack);
        int  v;
        bit  ovf;
        bit  run;
        bit  inc;
        bit  wrote;
        run   = m_tcon[4] && (!m_tmod[3] || m_int0);
        inc   = tk && run && !m_tmod[2];
        wrote = we && (a == A_TL0 || a == A_TH0);
        ovf   = 1'b0;
        if (inc && !wrote) begin
            case (m_tmod[1:0])
                2'd0: begin
                    v    = int'(m_th) * 32 + (int'(m_tl) % 32) + 1;
                    ovf  = (v == 8192);
                    v    = v % 8192;
                    m_th = 8'(v / 32);
                    m_tl = (m_tl & 8'hE0) | 8'(v % 32);
                end
                2'd1: begin
                    v    = int'(m_th) * 256 + int'(m_tl) + 1;
                    ovf  = (v == 65536);
                    v    = v % 65536;
                    m_th = 8'(v / 256);
                    m_tl = 8'(v % 256);
                end
                2'd2: begin
                    if (m_tl == 8'd255) begin
                        m_tl = m_th;
                        ovf  = 1'b1;
                    end else begin
                        m_tl = m_tl + 8'd1;
                    end
                end
                default: begin
                    ovf  = (m_tl == 8'd255);
                    m_tl = 8'((int'(m_tl) + 1) % 256);
                end
            endcase
        end
        if (we && a == A_TMOD) m_tmod = d;
        if (we && a == A_TL0)  m_tl = d;
        if (we && a == A_TH0)  m_th = d;
        if (we && a == A_TCON) m_tcon = d;
        else if (ack) m_tcon = m_tcon & 8'hDF;
        if (ovf) m_tcon = m_tcon | 8'h20;
    endtask

    // Drives one randomized bus/tick cycle into the DUT and the model.
    task automatic applyStimulus(input bit tk, input bit we, input logic [7:0] a,
                                 input logic [7:0] d, input bit ack);
        sfr_addr  = a;
        sfr_wdata = d;
        sfr_we    = we;
        mc_tick   = tk;
        int_ack   = ack;
        cycle();
        sfr_we  = 1'b0;
        mc_tick = 1'b0;
        int_ack = 1'b0;
        model_step(tk, we, a, d, ack);
        if (tk) repeat (11) cycle();
    endtask

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return A_TMOD;
            1: return A_TCON;
            2: return A_TL0;
            default: return A_TH0;
        endcase
    endfunction

    function automatic logic [7:0] rand_data(input logic [7:0] a);
        logic [7:0] r;
        r = 8'($urandom);
        if (a == A_TCON && $urandom_range(0, 3) != 0) r = r | 8'h10;
        if ((a == A_TL0 || a == A_TH0) && $urandom_range(0, 1) == 1) r = r | 8'hF8;
        return r;
    endfunction

    initial begin
        logic [7:0] d;
        logic [7:0] a;
        bit         exp_hit;
        int         op;

        vecs[0] = '{8'h01, 8'h10, 8'hFF, 8'hFD, 3,  8'h00, 8'h00, 1'b1};
        vecs[1] = '{8'h02, 8'h10, 8'hF0, 8'hFE, 2,  8'hF0, 8'hF0, 1'b1};
        vecs[2] = '{8'h00, 8'h10, 8'hFF, 8'h1E, 2,  8'h00, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h10, 8'h12, 8'hE5, 30, 8'h13, 8'hE3, 1'b0};
        vecs[4] = '{8'h03, 8'h10, 8'hAB, 8'hFE, 3,  8'hAB, 8'h01, 1'b1};
        vecs[5] = '{8'h01, 8'h10, 8'h12, 8'hFF, 1,  8'h13, 8'h00, 1'b0};
        vecs[6] = '{8'h02, 8'h10, 8'h80, 8'h10, 5,  8'h80, 8'h15, 1'b0};
        vecs[7] = '{8'h01, 8'h00, 8'h34, 8'h56, 4,  8'h34, 8'h56, 1'b0};
        vecs[8] = '{8'h09, 8'h10, 8'h00, 8'h00, 4,  8'h00, 8'h04, 1'b0};
        vecs[9] = '{8'h05, 8'h10, 8'h00, 8'h00, 4,  8'h00, 8'h00, 1'b0};

        // Reset values and address decode
        do_reset();
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            sfr_addr = a;
            #1;
            exp_hit = (a == 8'h88 || a == 8'h89 || a == 8'h8A || a == 8'h8C);
            checkOutput($sformatf("hit %h", a), {7'd0, sfr_hit}, {7'd0, exp_hit});
        end
        cycle();

        // Table-driven mode vectors
        for (int i = 0; i < 10; i++) begin
            do_reset();
            wr(A_TMOD, vecs[i].tmod);
            wr(A_TH0, vecs[i].th);
            wr(A_TL0, vecs[i].tl);
            wr(A_TCON, vecs[i].tcon);
            for (int k = 0; k < vecs[i].ticks; k++) tick();
            check_regs($sformatf("vec%0d", i), vecs[i].tmod,
                       vecs[i].tcon | {2'b00, vecs[i].exp_tf, 5'b00000},
                       vecs[i].exp_tl, vecs[i].exp_th);
        end

        // Mode 1 overflow then int_ack, count continues from 0000
        do_reset();
        wr(A_TMOD, 8'h01); wr(A_TH0, 8'hFF); wr(A_TL0, 8'hFD); wr(A_TCON, 8'h10);
        repeat (3) tick();
        checkOutput("m1 tf0 set", {7'd0, tf0}, 8'h01);
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;
        checkOutput("m1 tf0 after ack", {7'd0, tf0}, 8'h00);
        tick();
        check_regs("m1 continue", 8'h01, 8'h10, 8'h01, 8'h00);

        // Mode 2 second overflow after 16 further ticks
        do_reset();
        wr(A_TMOD, 8'h02); wr(A_TH0, 8'hF0); wr(A_TL0, 8'hFE); wr(A_TCON, 8'h10);
        repeat (2) tick();
        check_regs("m2 first", 8'h02, 8'h30, 8'hF0, 8'hF0);
        wr(A_TCON, 8'h10);
        repeat (15) tick();
        check_regs("m2 pre", 8'h02, 8'h10, 8'hFF, 8'hF0);
        tick();
        check_regs("m2 second", 8'h02, 8'h30, 8'hF0, 8'hF0);

        // Counter mode with gating
        do_reset();
        wr(A_TMOD, 8'h0D); wr(A_TCON, 8'h10);
        for (int i = 1; i <= 5; i++) begin
            t0_pulse();
            rd(A_TL0, d);
            checkOutput($sformatf("cnt pulse %0d", i), d, 8'(i));
        end
        int0_n = 1'b0;
        repeat (3) cycle();
        repeat (5) t0_pulse();
        rd(A_TL0, d);
        checkOutput("cnt gated", d, 8'h05);
        int0_n = 1'b1;
        repeat (3) cycle();
        t0_pulse();
        rd(A_TL0, d);
        checkOutput("cnt ungated", d, 8'h06);

        // TL0 write coincident with an increment
        do_reset();
        wr(A_TMOD, 8'h01); wr(A_TL0, 8'h10); wr(A_TCON, 8'h10);
        sfr_addr = A_TL0; sfr_wdata = 8'h55; sfr_we = 1'b1; mc_tick = 1'b1;
        cycle();
        sfr_we = 1'b0; mc_tick = 1'b0;
        check_regs("tl0 collide", 8'h01, 8'h10, 8'h55, 8'h00);

        // TH0 write coincident with a would-be overflow
        wr(A_TL0, 8'hFF); wr(A_TH0, 8'hFF);
        sfr_addr = A_TH0; sfr_wdata = 8'hAA; sfr_we = 1'b1; mc_tick = 1'b1;
        cycle();
        sfr_we = 1'b0; mc_tick = 1'b0;
        check_regs("th0 collide", 8'h01, 8'h10, 8'hFF, 8'hAA);

        // Overflow coincident with a TCON write of 10
        wr(A_TH0, 8'hFF);
        sfr_addr = A_TCON; sfr_wdata = 8'h10; sfr_we = 1'b1; mc_tick = 1'b1;
        cycle();
        sfr_we = 1'b0; mc_tick = 1'b0;
        check_regs("tcon collide", 8'h01, 8'h30, 8'h00, 8'h00);

        // Overflow coincident with int_ack
        wr(A_TCON, 8'h10); wr(A_TL0, 8'hFF); wr(A_TH0, 8'hFF);
        int_ack = 1'b1; mc_tick = 1'b1;
        cycle();
        int_ack = 1'b0; mc_tick = 1'b0;
        checkOutput("ack collide tf0", {7'd0, tf0}, 8'h01);

        // TMOD write takes effect for counting from the next CLK
        wr(A_TCON, 8'h10); wr(A_TH0, 8'h05); wr(A_TL0, 8'hFF);
        sfr_addr = A_TMOD; sfr_wdata = 8'h02; sfr_we = 1'b1; mc_tick = 1'b1;
        cycle();
        sfr_we = 1'b0; mc_tick = 1'b0;
        check_regs("tmod collide", 8'h02, 8'h10, 8'h00, 8'h06);

        // Reset asserted mid-count with TF0 set
        wr(A_TMOD, 8'h01); wr(A_TH0, 8'hFF); wr(A_TL0, 8'hFE); wr(A_TCON, 8'h10);
        repeat (3) tick();
        checkOutput("pre-reset tf0", {7'd0, tf0}, 8'h01);
        #3;
        reset = 1'b1;
        #1;
        check_regs("mid reset", 8'h00, 8'h00, 8'h00, 8'h00);
        cycle();
        reset = 1'b0;
        cycle();

        // Randomized run against the arithmetic model
        do_reset();
        m_tmod = 8'h00; m_tcon = 8'h00; m_tl = 8'h00; m_th = 8'h00; m_int0 = 1'b1;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            a  = rand_addr();
            d  = rand_data(a);
            case (op)
                0, 1: applyStimulus(1'b0, 1'b1, a, d, 1'b0);
                2, 3, 4, 5: applyStimulus(1'b1, 1'b0, a, d, 1'b0);
                6: applyStimulus(1'b1, 1'b1, a, d, 1'b0);
                7: applyStimulus(1'b0, 1'b0, a, d, 1'b1);
                8: applyStimulus(1'b1, 1'b0, a, d, 1'b1);
                default: begin
                    int0_n = 1'($urandom_range(0, 1));
                    m_int0 = int0_n;
                    repeat (3) cycle();
                end
            endcase
            check_regs($sformatf("rand%0d", n), m_tmod, m_tcon, m_tl, m_th);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
